// File: rtl/output_port_allocator.sv
// output_port_allocator
//
// Switch allocator for one output port of the quadtree router. NUM_IN input
// ports compete for the output unit. When LOCAL_PORT=1 the merge (reduction)
// path also competes. Arbitration is round robin. A multi-flit packet locks
// the port until its tail. No grant is issued unless the output unit reports
// a downstream credit.
//
// Optional feature (macro OUT_ALLOC_MERGE_FAIR_EN):
//   When the macro is defined, a merge-burst counter lets the merge path win
//   at most MERGE_BURST IDLE arbitrations in a row while an eligible head
//   flit is waiting. After that, the round-robin winner gets one turn.
//   When the macro is undefined, merge always wins IDLE arbitration.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req           input i has a flit for this output
//   req_head      flit on input i is a head flit
//   req_tail      flit on input i is a tail flit (head&tail = single flit)
//   merge_req     merge path has a word ready (ignored if LOCAL_PORT=0)
//   credit_avail  downstream credit > 0
//   credit_decre  consume one credit this cycle (combinational)
//   grant         one-hot SA grant, pops the input buffer (combinational)
//   merge_grant   merge path granted (combinational)
//   st_sel        registered one-hot crossbar select (ST stage)
//   out_unit_en   registered output unit update enable
//   merge_en      registered output unit merge enable
//   locked        registered; 1 while a multi-flit packet owns the port
//
// Handshake: a requester holds req (with head/tail qualifiers) until it
// sees its grant bit in the same cycle. A grant means the flit is consumed
// at this clock edge. It drives ST one cycle later through st_sel and
// out_unit_en (or merge_en).

module output_port_allocator #(
  parameter int NUM_IN      = 5,
  parameter int IDX_WIDTH   = 3,
  parameter int LOCAL_PORT  = 0,
  parameter int MERGE_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] req_head,
  input  logic [NUM_IN-1:0] req_tail,
  input  logic              merge_req,
  input  logic              credit_avail,
  output logic              credit_decre,
  output logic [NUM_IN-1:0] grant,
  output logic              merge_grant,
  output logic [NUM_IN-1:0] st_sel,
  output logic              out_unit_en,
  output logic              merge_en,
  output logic              locked
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state, state_n;
  logic [IDX_WIDTH-1:0] owner, owner_n;
  logic [IDX_WIDTH-1:0] rr_ptr, rr_ptr_n;

  logic [NUM_IN-1:0]    elig;
  logic [NUM_IN-1:0]    win_oh;
  logic [NUM_IN-1:0]    owner_oh;
  logic                 any_elig;
  logic                 found;
  logic                 merge_cand;
  logic                 merge_win;
  logic                 own_req;
  logic                 own_tail;
  logic [IDX_WIDTH-1:0] win_next;

  logic [NUM_IN-1:0]    grant_c;
  logic                 merge_grant_c;

`ifdef OUT_ALLOC_MERGE_FAIR_EN
  localparam int BW = (MERGE_BURST < 1) ? 1 : $clog2(MERGE_BURST + 1);
  logic [BW-1:0] burst_cnt, burst_cnt_n;
  logic          burst_full;
`endif

  // Round-robin search. Pass 1 covers inputs at or above rr_ptr. Pass 2
  // wraps to the inputs below it. The first eligible input found wins.
  // win_next is the pointer value that follows the winner.
  always_comb begin
    elig     = req & req_head;
    any_elig = |elig;
    win_oh   = '0;
    win_next = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found && elig[i] && (IDX_WIDTH'(i) >= rr_ptr)) begin
        found     = 1'b1;
        win_oh[i] = 1'b1;
        win_next  = (i == NUM_IN - 1) ? '0 : IDX_WIDTH'(i + 1);
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found && elig[i] && (IDX_WIDTH'(i) < rr_ptr)) begin
        found     = 1'b1;
        win_oh[i] = 1'b1;
        win_next  = (i == NUM_IN - 1) ? '0 : IDX_WIDTH'(i + 1);
      end
    end
  end

  // Decode the owner index. An owner index out of range selects nothing.
  always_comb begin
    owner_oh = '0;
    own_req  = 1'b0;
    own_tail = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (owner == IDX_WIDTH'(i)) begin
        owner_oh[i] = 1'b1;
        own_req     = req[i];
        own_tail    = req_tail[i];
      end
    end
  end

  assign merge_cand = (LOCAL_PORT != 0) && merge_req;

`ifdef OUT_ALLOC_MERGE_FAIR_EN
  assign burst_full = (burst_cnt == BW'(MERGE_BURST));
  // A full burst yields one turn, but only if a head flit is actually waiting.
  assign merge_win  = merge_cand && !(burst_full && any_elig);
`else
  assign merge_win  = merge_cand;
`endif

  // Next-state and grant logic. Reset forces every combinational grant to 0.
  always_comb begin
    state_n       = state;
    owner_n       = owner;
    rr_ptr_n      = rr_ptr;
    grant_c       = '0;
    merge_grant_c = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (credit_avail) begin
            if (merge_win) begin
              merge_grant_c = 1'b1;
            end else if (any_elig) begin
              grant_c  = win_oh;
              rr_ptr_n = win_next;
              // Only a head without a tail opens a packet. A single-flit
              // packet leaves the port free.
              if (|(win_oh & ~req_tail)) begin
                state_n = LOCKED;
                for (int i = 0; i < NUM_IN; i++) begin
                  if (win_oh[i]) owner_n = IDX_WIDTH'(i);
                end
              end
            end
          end
        end
        LOCKED: begin
          if (own_req && credit_avail) begin
            grant_c = owner_oh;
            if (own_tail) state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef OUT_ALLOC_MERGE_FAIR_EN
  // The counter saturates at MERGE_BURST. Any switch grant clears it,
  // including a grant that wins because the burst was full.
  always_comb begin
    burst_cnt_n = burst_cnt;
    if (merge_grant_c) begin
      if (!burst_full) burst_cnt_n = burst_cnt + BW'(1);
    end else if (|grant_c) begin
      burst_cnt_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) burst_cnt <= '0;
    else     burst_cnt <= burst_cnt_n;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      st_sel      <= '0;
      out_unit_en <= 1'b0;
      merge_en    <= 1'b0;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      rr_ptr      <= rr_ptr_n;
      st_sel      <= grant_c;
      out_unit_en <= |grant_c;
      merge_en    <= merge_grant_c;
    end
  end

  assign grant        = grant_c;
  assign merge_grant  = merge_grant_c;
  assign credit_decre = (|grant_c) | merge_grant_c;
  assign locked       = (state == LOCKED);

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed testbench for output_port_allocator (NUM_IN=5, LOCAL_PORT=1,
// MERGE_BURST=4). Inputs change 1 time unit after the rising edge.
// Combinational outputs are checked 1 time unit after that. Registered
// outputs are checked 1 time unit after the next rising edge, against an
// expected queue of the grants issued in the previous cycle.

module tb_output_port_allocator;

  localparam int N = 5;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] req_head;
  logic [N-1:0] req_tail;
  logic         merge_req;
  logic         credit_avail;
  logic         credit_decre;
  logic [N-1:0] grant;
  logic         merge_grant;
  logic [N-1:0] st_sel;
  logic         out_unit_en;
  logic         merge_en;
  logic         locked;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  output_port_allocator #(
    .NUM_IN(N), .IDX_WIDTH(3), .LOCAL_PORT(1), .MERGE_BURST(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_head(req_head), .req_tail(req_tail),
    .merge_req(merge_req), .credit_avail(credit_avail),
    .credit_decre(credit_decre), .grant(grant), .merge_grant(merge_grant),
    .st_sel(st_sel), .out_unit_en(out_unit_en), .merge_en(merge_en),
    .locked(locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // driver
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] h,
                       input logic [N-1:0] t, input logic m, input logic c);
    req = r; req_head = h; req_tail = t; merge_req = m; credit_avail = c;
  endtask

  // One cycle: check the combinational grants, advance the clock, then check
  // the ST-stage registers against the queued grant and check locked.
  task automatic step(input string tag, input logic [N-1:0] eg,
                      input logic em, input logic el);
    logic [N:0] e;
    #1;
    check({tag, ".grant"}, 32'(grant), 32'(eg));
    check({tag, ".merge_grant"}, 32'(merge_grant), 32'(em));
    check({tag, ".credit_decre"}, 32'(credit_decre), 32'((|eg) | em));
    exp_q.push_back({em, eg});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check({tag, ".st_sel"}, 32'(st_sel), 32'(e[N-1:0]));
    check({tag, ".out_unit_en"}, 32'(out_unit_en), 32'(|e[N-1:0]));
    check({tag, ".merge_en"}, 32'(merge_en), 32'(e[N]));
    check({tag, ".locked"}, 32'(locked), 32'(el));
  endtask

  initial begin
    rst = 1'b1;
    drive('0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset then idle. Requests applied during reset must not be granted.
    step("rst0", 5'b00000, 1'b0, 1'b0);
    drive(5'b11111, 5'b11111, 5'b11111, 1'b1, 1'b1);
    step("rst1", 5'b00000, 1'b0, 1'b0);
    rst = 1'b0;
    drive('0, '0, '0, 1'b0, 1'b1);
    step("idle", 5'b00000, 1'b0, 1'b0);

    // Round robin over inputs 0, 1 and 4 (single-flit packets).
    drive(5'b10011, 5'b10011, 5'b10011, 1'b0, 1'b1);
    step("rr0", 5'b00001, 1'b0, 1'b0);
    step("rr1", 5'b00010, 1'b0, 1'b0);
    step("rr2", 5'b10000, 1'b0, 1'b0);
    step("rr3", 5'b00001, 1'b0, 1'b0);
    step("rr4", 5'b00010, 1'b0, 1'b0);   // rr_ptr is now 2
    drive('0, '0, '0, 1'b0, 1'b1);
    step("rr_idle", 5'b00000, 1'b0, 1'b0);

    // Packet lock on input 2, while input 3 keeps offering a single-flit
    // head. A credit stall hits the second body flit.
    drive(5'b01100, 5'b01100, 5'b01000, 1'b0, 1'b1);
    step("pk_head", 5'b00100, 1'b0, 1'b1);
    drive(5'b01100, 5'b01000, 5'b01000, 1'b0, 1'b1);
    step("pk_body1", 5'b00100, 1'b0, 1'b1);
    drive(5'b01100, 5'b01000, 5'b01000, 1'b0, 1'b0);
    step("pk_stall", 5'b00000, 1'b0, 1'b1);
    drive(5'b01100, 5'b01000, 5'b01000, 1'b0, 1'b1);
    step("pk_body2", 5'b00100, 1'b0, 1'b1);
    drive(5'b01100, 5'b01000, 5'b01100, 1'b0, 1'b1);
    step("pk_tail", 5'b00100, 1'b0, 1'b0);
    drive(5'b01000, 5'b01000, 5'b01000, 1'b0, 1'b1);
    step("pk_next", 5'b01000, 1'b0, 1'b0);   // rr_ptr is now 4

    // Merge has priority over a head flit in IDLE.
    drive(5'b00010, 5'b00010, 5'b00010, 1'b1, 1'b1);
    step("mg_prio", 5'b00000, 1'b1, 1'b0);
    // No credit: neither merge nor switch is granted.
    drive(5'b00010, 5'b00010, 5'b00010, 1'b1, 1'b0);
    step("mg_nocred", 5'b00000, 1'b0, 1'b0);
    // Lock on input 1, then hold merge_req through the packet.
    drive(5'b00010, 5'b00010, 5'b00000, 1'b0, 1'b1);
    step("mg_lock", 5'b00010, 1'b0, 1'b1);
    drive(5'b00010, 5'b00000, 5'b00000, 1'b1, 1'b1);
    step("mg_body", 5'b00010, 1'b0, 1'b1);
    drive(5'b00010, 5'b00000, 5'b00010, 1'b1, 1'b1);
    step("mg_tail", 5'b00010, 1'b0, 1'b0);
    drive('0, '0, '0, 1'b1, 1'b1);
    step("mg_after", 5'b00000, 1'b1, 1'b0);   // rr_ptr is now 2

    // Reset mid-packet: lock on input 3, then reset. The next arbitration
    // starts from input 0.
    drive(5'b01000, 5'b01000, 5'b00000, 1'b0, 1'b1);
    step("rm_lock", 5'b01000, 1'b0, 1'b1);
    rst = 1'b1;
    drive(5'b01000, 5'b00000, 5'b00000, 1'b0, 1'b1);
    step("rm_rst", 5'b00000, 1'b0, 1'b0);
    rst = 1'b0;
    drive(5'b01001, 5'b01001, 5'b01001, 1'b0, 1'b1);
    step("rm_first", 5'b00001, 1'b0, 1'b0);

    // Merge fairness, with merge_req and a head on input 0 both held.
    drive(5'b00001, 5'b00001, 5'b00001, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
`ifdef OUT_ALLOC_MERGE_FAIR_EN
      if ((k % 5) == 4) step($sformatf("fair%0d", k), 5'b00001, 1'b0, 1'b0);
      else              step($sformatf("fair%0d", k), 5'b00000, 1'b1, 1'b0);
`else
      step($sformatf("fair%0d", k), 5'b00000, 1'b1, 1'b0);
`endif
    end

    drive('0, '0, '0, 1'b0, 1'b1);
    step("end_idle", 5'b00000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
